// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader: state encoding and default sizes.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_LEN_WIDTH = 8;

endpackage

// File: rtl/fifo_burst_reader.sv
// Reads a burst of len words from a fall-through FIFO and streams them out
// through a registered valid/ready output stage.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_get,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last
);

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [WIDTH-1:0]     DATA_ZERO = {WIDTH{1'b0}};

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic                 done_q, done_d;
    logic                 pop_s;
    logic                 handshake_s;

    // Pop whenever the output stage is free or being emptied this cycle.
    assign pop_s = (state_q == ST_READ) && !fifo_empty && !abort
                   && (!out_valid_q || out_ready) && (remaining_q != LEN_ZERO);
    assign handshake_s = out_valid_q && out_ready;

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && (len != LEN_ZERO)) begin
                    remaining_d = len;
                    state_d     = ST_READ;
                end else if (start) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    remaining_d = LEN_ZERO;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else if (pop_s) begin
                    out_data_d  = fifo_data;
                    out_valid_d = 1'b1;
                    out_last_d  = (remaining_q == LEN_ONE);
                    remaining_d = remaining_q - LEN_ONE;
                    state_d     = (remaining_q == LEN_ONE) ? ST_DRAIN : ST_READ;
                end else if (handshake_s) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                // Only the final word can be pending here; its acceptance ends the burst.
                if (abort) begin
                    state_d     = ST_IDLE;
                    remaining_d = LEN_ZERO;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else if (handshake_s) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = out_last_q;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                remaining_d = LEN_ZERO;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= LEN_ZERO;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= DATA_ZERO;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign fifo_get  = pop_s;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench: models the FIFO as a queue and checks each burst's output
// stream, pop count, done pulses and stall behaviour against expected word lists.
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        rst, start, abort, out_ready, fifo_empty;
    logic [7:0]  len;
    logic [31:0] fifo_data;
    logic        busy, done, fifo_get, out_valid, out_last;
    logic [31:0] out_data;

    logic [31:0] fq[$];
    logic [31:0] got_d[$];
    logic        got_l[$];
    int          got_c[$];
    int          cyc, pops, get_empty, dones, done_c, stall_err;
    logic        prev_stall, prev_last;
    logic [31:0] prev_data;
    int          total, bad;

    fifo_burst_reader dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .busy(busy), .done(done), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_get(fifo_get), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // One clock cycle: present FIFO head, observe outputs, pop on the edge.
    task automatic step();
        logic g;
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? 32'h0 : fq[0];
        #1;
        g = fifo_get;
        if (g) begin
            pops++;
            if (fifo_empty) get_empty++;
        end
        if (done) begin
            if (dones == 0) done_c = cyc;
            dones++;
        end
        if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
            stall_err++;
        prev_stall = out_valid && !out_ready && !abort && !rst;
        prev_data  = out_data;
        prev_last  = out_last;
        if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
            got_c.push_back(cyc);
        end
        @(posedge clk);
        if (g && fq.size() > 0) void'(fq.pop_front());
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_mon();
        pops = 0; get_empty = 0; dones = 0; done_c = -1; stall_err = 0;
        prev_stall = 1'b0;
        got_d.delete(); got_l.delete(); got_c.delete();
    endtask

    task automatic issue_start(input logic [7:0] l);
        start = 1'b1; len = l;
        step();
        start = 1'b0; len = 8'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%0b exp=0", out_last); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%0h exp=0", out_data); end
    endtask

    task automatic test_basic();
        logic [31:0] exp[$];
        int s;
        clear_mon();
        exp = '{32'hA, 32'hB, 32'hC, 32'hD};
        fq = exp;
        out_ready = 1'b1;
        s = cyc;
        issue_start(8'd4);
        for (int i = 0; i < 10; i++) step();
        total++; if (got_d.size() != 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            total++; if (got_d[i] !== exp[i]) begin bad++; $display("FAIL basic_data[%0d] got=%0h exp=%0h", i, got_d[i], exp[i]); end
            total++; if (got_l[i] !== (i == 3)) begin bad++; $display("FAIL basic_last[%0d] got=%0b exp=%0b", i, got_l[i], i == 3); end
            total++; if (got_c[i] != s + 2 + i) begin bad++; $display("FAIL basic_cycle[%0d] got=%0d exp=%0d", i, got_c[i], s + 2 + i); end
        end
        total++; if (dones != 1) begin bad++; $display("FAIL basic_dones got=%0d exp=1", dones); end
        total++; if (done_c != s + 6) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=%0d", done_c, s + 6); end
        total++; if (pops != 4) begin bad++; $display("FAIL basic_pops got=%0d exp=4", pops); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%0b exp=0", busy); end
    endtask

    task automatic test_underflow();
        logic [31:0] exp[$];
        clear_mon();
        exp = '{32'h11, 32'h22, 32'h33};
        fq.push_back(exp[0]);
        out_ready = 1'b1;
        issue_start(8'd3);
        for (int i = 0; i < 5; i++) step();
        fq.push_back(exp[1]);
        fq.push_back(exp[2]);
        for (int i = 0; i < 12; i++) step();
        total++; if (get_empty != 0) begin bad++; $display("FAIL under_get_while_empty got=%0d exp=0", get_empty); end
        total++; if (got_d.size() != 3) begin bad++; $display("FAIL under_count got=%0d exp=3", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 3; i++) begin
            total++; if (got_d[i] !== exp[i]) begin bad++; $display("FAIL under_data[%0d] got=%0h exp=%0h", i, got_d[i], exp[i]); end
        end
        total++; if (dones != 1) begin bad++; $display("FAIL under_dones got=%0d exp=1", dones); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp[$];
        clear_mon();
        exp = '{32'h5, 32'h6, 32'h7, 32'h8};
        fq = '{32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 32'hA};
        out_ready = 1'b1;
        issue_start(8'd4);
        for (int i = 0; i < 30; i++) begin
            out_ready = ((i % 4) == 0) || ((i % 4) == 3);
            step();
        end
        out_ready = 1'b1;
        total++; if (stall_err != 0) begin bad++; $display("FAIL bp_stall_hold got=%0d exp=0", stall_err); end
        total++; if (got_d.size() != 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            total++; if (got_d[i] !== exp[i]) begin bad++; $display("FAIL bp_data[%0d] got=%0h exp=%0h", i, got_d[i], exp[i]); end
        end
        total++; if (pops != 4) begin bad++; $display("FAIL bp_pops got=%0d exp=4", pops); end
        total++; if (fq.size() != 2) begin bad++; $display("FAIL bp_fifo_left got=%0d exp=2", fq.size()); end
        total++; if (dones != 1) begin bad++; $display("FAIL bp_dones got=%0d exp=1", dones); end
        fq.delete();
    endtask

    task automatic test_zero_len();
        clear_mon();
        fq.push_back(32'hEE);
        out_ready = 1'b1;
        issue_start(8'd0);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%0b exp=1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%0b exp=0", busy); end
        step(); step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse got=%0b exp=0", done); end
        total++; if (pops != 0) begin bad++; $display("FAIL zero_pops got=%0d exp=0", pops); end
        total++; if (dones != 1) begin bad++; $display("FAIL zero_dones got=%0d exp=1", dones); end
        fq.delete();
    endtask

    task automatic test_abort();
        clear_mon();
        fq = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104};
        out_ready = 1'b1;
        issue_start(8'd5);
        for (int i = 0; i < 50 && got_d.size() < 2; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b exp=0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%0b exp=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL abort_last got=%0b exp=0", out_last); end
        for (int i = 0; i < 5; i++) step();
        total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
        fq.delete();
        clear_mon();
        fq.push_back(32'hCAFE);
        issue_start(8'd1);
        for (int i = 0; i < 8; i++) step();
        total++; if (got_d.size() != 1) begin bad++; $display("FAIL after_abort_count got=%0d exp=1", got_d.size()); end
        if (got_d.size() > 0) begin
            total++; if (got_d[0] !== 32'hCAFE) begin bad++; $display("FAIL after_abort_data got=%0h exp=cafe", got_d[0]); end
            total++; if (got_l[0] !== 1'b1) begin bad++; $display("FAIL after_abort_last got=%0b exp=1", got_l[0]); end
        end
        total++; if (dones != 1) begin bad++; $display("FAIL after_abort_dones got=%0d exp=1", dones); end
    endtask

    task automatic test_busy_start_rst();
        logic [31:0] exp[$];
        clear_mon();
        exp = '{32'h200, 32'h201, 32'h202};
        fq = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h204, 32'h205};
        out_ready = 1'b1;
        issue_start(8'd3);
        issue_start(8'd7);
        for (int i = 0; i < 50 && got_d.size() < 2; i++) step();
        out_ready = 1'b0;
        for (int i = 0; i < 20 && !(out_valid && out_last); i++) step();
        total++; if (!(out_valid && out_last)) begin bad++; $display("FAIL drain_reached got=%0b exp=1", out_valid && out_last); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_last got=%0b exp=0", out_last); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%0h exp=0", out_data); end
        for (int i = 0; i < 4; i++) step();
        total++; if (dones != 0) begin bad++; $display("FAIL rst_no_done got=%0d exp=0", dones); end
        total++; if (pops != 3) begin bad++; $display("FAIL busy_start_pops got=%0d exp=3", pops); end
        total++; if (fq.size() != 3) begin bad++; $display("FAIL busy_start_fifo_left got=%0d exp=3", fq.size()); end
        for (int i = 0; i < got_d.size() && i < 2; i++) begin
            total++; if (got_d[i] !== exp[i]) begin bad++; $display("FAIL busy_data[%0d] got=%0h exp=%0h", i, got_d[i], exp[i]); end
        end
        fq.delete();
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            logic [31:0] exp[$];
            int l, pushed, last_bad;
            clear_mon();
            l = $urandom_range(1, 8);
            for (int i = 0; i < l; i++) exp.push_back($urandom);
            pushed = $urandom_range(0, l);
            for (int i = 0; i < pushed; i++) fq.push_back(exp[i]);
            out_ready = 1'b1;
            issue_start(8'(l));
            for (int i = 0; i < 200; i++) begin
                if (pushed < l && ($urandom_range(0, 2) == 0 || i > 100)) begin
                    fq.push_back(exp[pushed]);
                    pushed++;
                end
                out_ready = ($urandom_range(0, 3) != 0);
                step();
            end
            out_ready = 1'b1;
            last_bad = 0;
            for (int i = 0; i < got_l.size(); i++)
                if (got_l[i] !== (i == l - 1)) last_bad++;
            total++; if (got_d.size() != l) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", b, got_d.size(), l); end
            for (int i = 0; i < got_d.size() && i < l; i++) begin
                total++; if (got_d[i] !== exp[i]) begin bad++; $display("FAIL rnd%0d_data[%0d] got=%0h exp=%0h", b, i, got_d[i], exp[i]); end
            end
            total++; if (last_bad != 0) begin bad++; $display("FAIL rnd%0d_last got=%0d exp=0", b, last_bad); end
            total++; if (pops != l) begin bad++; $display("FAIL rnd%0d_pops got=%0d exp=%0d", b, pops, l); end
            total++; if (get_empty != 0) begin bad++; $display("FAIL rnd%0d_get_empty got=%0d exp=0", b, get_empty); end
            total++; if (stall_err != 0) begin bad++; $display("FAIL rnd%0d_stall got=%0d exp=0", b, stall_err); end
            total++; if (dones != 1) begin bad++; $display("FAIL rnd%0d_dones got=%0d exp=1", b, dones); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd%0d_busy got=%0b exp=0", b, busy); end
            fq.delete();
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        len = 8'd0; fifo_empty = 1'b1; fifo_data = 32'h0;
        clear_mon();
        @(negedge clk);
        test_reset();
        test_basic();
        test_underflow();
        test_backpressure();
        test_zero_len();
        test_abort();
        test_busy_start_rst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
